decode_writeback: RTL and testbench
===================================

Name: decode_writeback

Overview:
- SEQ-processor decode and write-back stage, downstream of fetch.
- Owns the 15-entry 64-bit Y86-64 register file.
- Derives srcA/srcB/dstE/dstM from the fetched icode/rA/rB, drives valA/valB combinationally to execute, and commits valE/valM on the clock edge that ends the instruction.

Parameters:
- WIDTH, 64, data width of each register.
- RSP_INIT, 64'd2048, reset value of %rsp (register 4); top of data memory.

Ports:
- clk  input  1  system clock; all register writes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- icode  input  4  instruction code from fetch.
- rA  input  4  register specifier A from fetch (0xF = none).
- rB  input  4  register specifier B from fetch (0xF = none).
- cnd  input  1  condition result from execute; qualifies the cmovXX write.
- valE  input  WIDTH  ALU result to write back.
- valM  input  WIDTH  memory read data to write back.
- wb_en  input  1  write-back permitted; low when status is halt/ins_er/adr_er.
- srcA  output  4  selected read index A.
- srcB  output  4  selected read index B.
- dstE  output  4  E-port write index.
- dstM  output  4  M-port write index.
- valA  output  WIDTH  register[srcA], or 0 if srcA = 0xF.
- valB  output  WIDTH  register[srcB], or 0 if srcB = 0xF.
- dbg_sel  input  4  debug read index for the bench.
- dbg_data  output  WIDTH  register[dbg_sel], or 0 if dbg_sel = 0xF.

Behaviour:
- Reset (rst_n low, async): all 15 registers clear to 0, except reg 4, which loads RSP_INIT.
  - Outputs follow combinationally from the reset contents.
  - Reset asserted mid-cycle discards any pending write.
- Index selection, combinational; icode values in hex:
  - srcA = rA for 2, 4, 6, A; 4 for 9, B; else F.
  - srcB = rB for 4, 5, 6; 4 for 8, 9, A, B; else F.
  - dstE:
    - icode 2: rB if cnd=1, else F.
    - icode 3, 6: rB.
    - icode 8, 9, A, B: 4.
    - else: F.
  - dstM = rA for 5, B; else F.
  - Undefined icodes (C–F) and 0, 1, 7 select F for all four indices.
- Reads are combinational with zero latency.
  - A write committed at posedge N is visible on valA/valB from just after edge N.
  - There is no same-cycle bypass: valA/valB always reflect pre-edge contents.
- Writes occur on posedge clk only when wb_en=1:
  - dstE != F: reg[dstE] <= valE.
  - dstM != F: reg[dstM] <= valM.
  - dstE == dstM != F (e.g. popq %rsp): valM wins, and reg[4] = valM.
- wb_en=0 suppresses both writes; register contents hold.
- Index 0xF is never written and always reads 0. There is no physical register 15.
- Full WIDTH-bit writes; no sign or width manipulation.

Test Plan:
- Reset:
  - Drive rst_n=0, then sweep dbg_sel 0..F.
  - Required: dbg_data=0 for all except sel=4 -> 2048, and sel=F -> 0.
- irmovq:
  - icode=3, rA=F, rB=2, valE=0x1234, wb_en=1, one posedge.
  - Required: before the edge dstE=2, srcA=srcB=F; after the edge dbg_data(2)=0x1234.
- OPq read/write:
  - Preload r1=5, r2=7; icode=6, rA=1, rB=2.
  - Required: valA=5, valB=7 before the edge; valE=12 written to r2 at the edge.
- cmov not taken:
  - icode=2, rA=1, rB=3, cnd=0, valE=9.
  - Required: dstE=F; r3 unchanged after the edge. Repeat with cnd=1 -> r3=9.
- popq %rsp conflict:
  - icode=B, rA=4, valE=2056, valM=0xAA.
  - Required: srcA=srcB=4, dstE=dstM=4; after the edge r4=0xAA.
- Write suppression and async reset:
  - icode=3, rB=5, valE=0x77, wb_en=0 -> r5 unchanged.
  - Then wb_en=1 with rst_n pulsed low between edges -> r5=0 and r4=2048 immediately, without waiting for clk.

Source files
------------

// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode / write-back stage.
// Owns the 15-entry register file; index 0xF means "no register".
module decode_writeback #(
    parameter int               WIDTH    = 64,
    parameter logic [WIDTH-1:0] RSP_INIT = WIDTH'(2048)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       icode,
    input  logic [3:0]       rA,
    input  logic [3:0]       rB,
    input  logic             cnd,
    input  logic [WIDTH-1:0] valE,
    input  logic [WIDTH-1:0] valM,
    input  logic             wb_en,
    output logic [3:0]       srcA,
    output logic [3:0]       srcB,
    output logic [3:0]       dstE,
    output logic [3:0]       dstM,
    output logic [WIDTH-1:0] valA,
    output logic [WIDTH-1:0] valB,
    input  logic [3:0]       dbg_sel,
    output logic [WIDTH-1:0] dbg_data
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [WIDTH-1:0] rf [15];

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        unique case (icode)
            4'h2: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            4'h3: dstE = rB;
            4'h4: begin
                srcA = rA;
                srcB = rB;
            end
            4'h5: begin
                srcB = rB;
                dstM = rA;
            end
            4'h6: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            4'h8: begin
                srcB = RSP;
                dstE = RSP;
            end
            4'h9: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            4'hA: begin
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            4'hB: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    // Index 0xF matches no entry, so it reads as zero.
    always_comb begin
        valA     = '0;
        valB     = '0;
        dbg_data = '0;
        for (int i = 0; i < 15; i++) begin
            if (srcA == 4'(i)) valA = rf[i];
            if (srcB == 4'(i)) valB = rf[i];
            if (dbg_sel == 4'(i)) dbg_data = rf[i];
        end
    end

    // M port is assigned last so it wins when dstE == dstM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++)
                rf[i] <= (i == 4) ? RSP_INIT : '0;
        end else if (wb_en) begin
            for (int i = 0; i < 15; i++) begin
                if (dstE == 4'(i)) rf[i] <= valE;
                if (dstM == 4'(i)) rf[i] <= valM;
            end
        end
    end

endmodule

// File: tb/tb_decode_writeback.sv
// Randomized scoreboard bench for decode_writeback.
// Reference model: plain array register file plus table-driven decode.
module tb_decode_writeback;

    logic        clk = 0;
    logic        rst_n = 0;
    logic [3:0]  icode = 4'h1, rA = 4'hF, rB = 4'hF;
    logic        cnd = 0;
    logic [63:0] valE = '0, valM = '0;
    logic        wb_en = 0;
    logic [3:0]  srcA, srcB, dstE, dstM, dbg_sel = 4'h0;
    logic [63:0] valA, valB, dbg_data;

    decode_writeback dut (
        .clk(clk), .rst_n(rst_n), .icode(icode), .rA(rA), .rB(rB),
        .cnd(cnd), .valE(valE), .valM(valM), .wb_en(wb_en),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM),
        .valA(valA), .valB(valB), .dbg_sel(dbg_sel),
        .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    event chk_ev;
    int total = 0;
    int bad = 0;

    logic [63:0] model [15];

    function automatic void model_reset();
        for (int i = 0; i < 15; i++) model[i] = (i == 4) ? 64'd2048 : 64'd0;
    endfunction

    function automatic logic [63:0] mread(input logic [3:0] r);
        return (r == 4'hF) ? 64'd0 : model[r];
    endfunction

    function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] a);
        if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return a;
        if (ic inside {4'h9, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] b);
        if (ic inside {4'h4, 4'h5, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] b,
                                          input logic c);
        if (ic == 4'h2) return c ? b : 4'hF;
        if (ic inside {4'h3, 4'h6}) return b;
        if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
        return 4'hF;
    endfunction

    function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] a);
        return (ic inside {4'h5, 4'hB}) ? a : 4'hF;
    endfunction

    function automatic void push(input int k, input logic [63:0] e, input string n);
        chk_t c;
        c.kind = k;
        c.exp  = e;
        c.name = n;
        q.push_back(c);
    endfunction

    always begin
        @(chk_ev);
        while (q.size() > 0) begin
            chk_t c;
            logic [63:0] act;
            c = q.pop_front();
            case (c.kind)
                0: act = {60'd0, srcA};
                1: act = {60'd0, srcB};
                2: act = {60'd0, dstE};
                3: act = {60'd0, dstM};
                4: act = valA;
                5: act = valB;
                default: act = dbg_data;
            endcase
            total++;
            if (act !== c.exp) begin
                bad++;
                $display("FAIL %s: got %h want %h", c.name, act, c.exp);
            end
        end
    end

    // Drive one instruction after posedge; expectations use pre-edge model.
    task automatic issue(input logic [3:0] ic, input logic [3:0] a,
                         input logic [3:0] b, input logic c,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic en, input logic [3:0] ds);
        logic [3:0] sa, sb, de, dm;
        @(posedge clk);
        #1;
        icode = ic; rA = a; rB = b; cnd = c;
        valE = ve; valM = vm; wb_en = en; dbg_sel = ds;
        #1;
        sa = m_srcA(ic, a);
        sb = m_srcB(ic, b);
        de = m_dstE(ic, b, c);
        dm = m_dstM(ic, a);
        push(0, {60'd0, sa}, "srcA");
        push(1, {60'd0, sb}, "srcB");
        push(2, {60'd0, de}, "dstE");
        push(3, {60'd0, dm}, "dstM");
        push(4, mread(sa), "valA");
        push(5, mread(sb), "valB");
        push(6, mread(ds), "dbg_data");
        -> chk_ev;
        if (en && rst_n) begin
            if (de != 4'hF) model[de] = ve;
            if (dm != 4'hF) model[dm] = vm;
        end
    endtask

    task automatic peek(input logic [3:0] ds);
        issue(4'h1, 4'hF, 4'hF, 1'b0, '0, '0, 1'b0, ds);
    endtask

    initial begin
        model_reset();
        for (int s = 0; s < 16; s++) peek(4'(s));
        @(posedge clk);
        #1 rst_n = 1;

        issue(4'h3, 4'hF, 4'h2, 0, 64'h1234, 0, 1, 4'h2);
        peek(4'h2);
        issue(4'h3, 4'hF, 4'h1, 0, 64'd5, 0, 1, 4'h1);
        issue(4'h3, 4'hF, 4'h2, 0, 64'd7, 0, 1, 4'h2);
        issue(4'h6, 4'h1, 4'h2, 0, 64'd12, 0, 1, 4'h2);
        peek(4'h2);
        issue(4'h2, 4'h1, 4'h3, 0, 64'd9, 0, 1, 4'h3);
        peek(4'h3);
        issue(4'h2, 4'h1, 4'h3, 1, 64'd9, 0, 1, 4'h3);
        peek(4'h3);
        issue(4'hB, 4'h4, 4'hF, 0, 64'd2056, 64'hAA, 1, 4'h4);
        peek(4'h4);
        issue(4'h3, 4'hF, 4'h5, 0, 64'h77, 0, 0, 4'h5);
        peek(4'h5);
        issue(4'h3, 4'hF, 4'h5, 0, 64'h55, 0, 1, 4'h5);

        for (int n = 0; n < 400; n++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  {$urandom(), $urandom()}, {$urandom(), $urandom()},
                  ($urandom_range(0, 4) != 0), 4'($urandom_range(0, 15)));
        end

        // Write to r5 pending, then async reset before the edge.
        issue(4'h3, 4'hF, 4'h5, 0, 64'h77, 0, 1, 4'h5);
        #1 rst_n = 0;
        model_reset();
        icode = 4'h9;
        #1;
        push(4, 64'd2048, "async_valA");
        push(5, 64'd2048, "async_valB");
        push(6, 64'd0, "async_r5");
        -> chk_ev;
        #1 icode = 4'h1;
        wb_en = 0;
        #1 rst_n = 1;
        peek(4'h5);
        peek(4'h4);

        @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
